// File: rtl/set_assoc_cache_array_pkg.sv
// Shared types for the set-associative cache array: line layout, MESI states and request opcodes.
package my_struct_package;

  localparam int LINE_TAG_W  = 12;
  localparam int LINE_DATA_W = 32;

  typedef enum logic [1:0] {
    MESI_M = 2'd0,
    MESI_E = 2'd1,
    MESI_S = 2'd2,
    MESI_I = 2'd3
  } mesi_e;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'd0,
    OP_WRITE  = 2'd1,
    OP_CLEAR  = 2'd2,
    OP_PRINT  = 2'd3
  } req_op_e;

  typedef struct packed {
    logic [LINE_TAG_W-1:0]  tag;
    mesi_e                  mesi;
    logic [LINE_DATA_W-1:0] data;
  } cache_line_t;

  function automatic logic line_valid(input cache_line_t line);
    return (line.mesi != MESI_I);
  endfunction

endpackage

// File: rtl/set_assoc_cache_array_if.sv
// Request/response bundle between a requester (master) and the cache array (slave).
interface set_assoc_cache_array_if
  import my_struct_package::*;
#(
  parameter int SETS  = 16384,
  parameter int WAYS  = 8,
  parameter int TAG_W = LINE_TAG_W
);
  localparam int SET_W = $clog2(SETS);
  localparam int IDX_W = $clog2(WAYS);

  logic              req_valid;
  logic              req_ready;
  req_op_e           req_op;
  logic [SET_W-1:0]  req_set;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_way;
  cache_line_t       req_line;
  logic              rsp_valid;
  logic              rsp_hit;
  logic [IDX_W-1:0]  rsp_way;
  cache_line_t       rsp_line;
  logic              busy;

  modport master (
    output req_valid, req_op, req_set, req_tag, req_way, req_line,
    input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_line, busy
  );

  modport slave (
    input  req_valid, req_op, req_set, req_tag, req_way, req_line,
    output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_line, busy
  );

endinterface

// File: rtl/set_assoc_cache_array_lru_update.sv
// Combinational LRU bookkeeping for one set: promote a touched way to MRU and pick a miss victim.
module lru_update #(
  parameter  int WAYS  = 8,
  localparam int IDX_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0][IDX_W-1:0] cnt_i,
  input  logic [WAYS-1:0]            inv_i,
  input  logic [IDX_W-1:0]           touch_i,
  output logic [WAYS-1:0][IDX_W-1:0] cnt_o,
  output logic [IDX_W-1:0]           victim_o
);

  logic [IDX_W-1:0] touch_cnt_s;
  logic [IDX_W-1:0] lru_way_s;

  // Ways more recent than the touched one age by one, keeping the counters a permutation.
  always_comb begin
    touch_cnt_s = cnt_i[touch_i];
    cnt_o       = cnt_i;
    for (int w = 0; w < WAYS; w++) begin
      if (IDX_W'(w) == touch_i) begin
        cnt_o[w] = {IDX_W{1'b0}};
      end else if (cnt_i[w] < touch_cnt_s) begin
        cnt_o[w] = cnt_i[w] + IDX_W'(1'b1);
      end else begin
        cnt_o[w] = cnt_i[w];
      end
    end
  end

  // Lowest invalid way wins; otherwise the way holding the oldest counter.
  always_comb begin
    lru_way_s = {IDX_W{1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      if (cnt_i[w] == IDX_W'(WAYS - 1)) begin
        lru_way_s = IDX_W'(w);
      end else begin
        lru_way_s = lru_way_s;
      end
    end
    victim_o = lru_way_s;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (inv_i[w]) begin
        victim_o = IDX_W'(w);
      end else begin
        victim_o = victim_o;
      end
    end
  end

endmodule

// File: rtl/set_assoc_cache_array.sv
// Set-associative tag/data array with per-set LRU serving LOOKUP/WRITE/CLEAR/PRINT requests.
// Define CACHE_DEBUG_PRINT_EN to trace PRINT requests and clear-sweep completion.
module set_assoc_cache_array
  import my_struct_package::*;
#(
  parameter int SETS   = 16384,
  parameter int WAYS   = 8,
  parameter int TAG_W  = LINE_TAG_W,
  parameter int DATA_W = LINE_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  set_assoc_cache_array_if.slave   bus
);

  localparam int SET_W = $clog2(SETS);
  localparam int IDX_W = $clog2(WAYS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam logic [SET_W-1:0] LAST_SET = SET_W'(SETS - 1);

  cache_line_t [WAYS-1:0]      lines_q [SETS];
  logic [WAYS-1:0][IDX_W-1:0]  lru_q   [SETS];

  logic [1:0]        state_q, state_d;
  logic [SET_W-1:0]  sweep_q, sweep_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_hit_q, rsp_hit_d;
  logic [IDX_W-1:0]  rsp_way_q, rsp_way_d;
  cache_line_t       rsp_line_q, rsp_line_d;

  cache_line_t [WAYS-1:0]      set_lines_s;
  logic [WAYS-1:0][IDX_W-1:0]  set_lru_s;
  logic [WAYS-1:0][IDX_W-1:0]  lru_next_s;
  logic [WAYS-1:0]             inv_s;
  logic                        hit_s;
  logic                        accept_s;
  logic [IDX_W-1:0]            hit_way_s;
  logic [IDX_W-1:0]            victim_s;
  logic [IDX_W-1:0]            touch_way_s;
  logic [IDX_W-1:0]            pick_way_s;

  assign accept_s    = bus.req_valid & ready_q;
  assign set_lines_s = lines_q[bus.req_set];
  assign set_lru_s   = lru_q[bus.req_set];
  assign touch_way_s = (bus.req_op == OP_WRITE) ? bus.req_way : hit_way_s;
  assign pick_way_s  = hit_s ? hit_way_s : victim_s;

  // Tag compare over the addressed set; the descending scan lets the lowest matching way win.
  always_comb begin
    hit_s     = 1'b0;
    hit_way_s = {IDX_W{1'b0}};
    inv_s     = {WAYS{1'b0}};
    for (int w = WAYS - 1; w >= 0; w--) begin
      inv_s[w] = !line_valid(set_lines_s[w]);
      if (!inv_s[w] && (set_lines_s[w].tag == bus.req_tag)) begin
        hit_s     = 1'b1;
        hit_way_s = IDX_W'(w);
      end else begin
        hit_way_s = hit_way_s;
      end
    end
  end

  lru_update #(.WAYS(WAYS)) u_lru_update (
    .cnt_i    (set_lru_s),
    .inv_i    (inv_s),
    .touch_i  (touch_way_s),
    .cnt_o    (lru_next_s),
    .victim_o (victim_s)
  );

  // Control FSM next state; response fields hold their last value between lookups.
  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    rsp_valid_d = 1'b0;
    rsp_hit_d   = rsp_hit_q;
    rsp_way_d   = rsp_way_q;
    rsp_line_d  = rsp_line_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && (bus.req_op == OP_LOOKUP)) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_hit_d   = hit_s;
          rsp_way_d   = pick_way_s;
          rsp_line_d  = set_lines_s[pick_way_s];
        end else if (accept_s && (bus.req_op == OP_CLEAR)) begin
          state_d = ST_CLEAR;
          sweep_d = {SET_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        sweep_d = sweep_q + SET_W'(1'b1);
        if (sweep_q == LAST_SET) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d == ST_CLEAR);
  end

  // Control and response registers; reset lands in a fresh sweep from set 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      sweep_q     <= {SET_W{1'b0}};
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_way_q   <= {IDX_W{1'b0}};
      rsp_line_q  <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_way_q   <= rsp_way_d;
      rsp_line_q  <= rsp_line_d;
    end
  end

  // Array storage is not reset; the sweep initialises it one set per cycle.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      for (int w = 0; w < WAYS; w++) begin
        lines_q[sweep_q][w].tag  <= {TAG_W{1'b0}};
        lines_q[sweep_q][w].mesi <= MESI_I;
        lines_q[sweep_q][w].data <= {DATA_W{1'b0}};
        lru_q[sweep_q][w]        <= IDX_W'(w);
      end
    end else if (accept_s && (bus.req_op == OP_WRITE)) begin
      lines_q[bus.req_set][bus.req_way] <= bus.req_line;
      lru_q[bus.req_set]                <= lru_next_s;
    end else if (accept_s && (bus.req_op == OP_LOOKUP) && hit_s) begin
      lru_q[bus.req_set] <= lru_next_s;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_hit   = rsp_hit_q;
  assign bus.rsp_way   = rsp_way_q;
  assign bus.rsp_line  = rsp_line_q;

`ifdef CACHE_DEBUG_PRINT_EN
  // Trace PRINT requests and the end of every clear sweep.
  always_ff @(posedge clk) begin
    if (!rst && accept_s && (bus.req_op == OP_PRINT)) begin
      $display("%0t set %0d", $time, bus.req_set);
      for (int w = 0; w < WAYS; w++) begin
        $display("  way %0d tag %h mesi %0d data %h", w, set_lines_s[w].tag,
                 set_lines_s[w].mesi, set_lines_s[w].data);
      end
    end
    if (!rst && (state_q == ST_CLEAR) && (sweep_q == LAST_SET)) begin
      $display("reset");
    end
  end
`endif

endmodule

// File: doc/set_assoc_cache_array.md
SET_ASSOC_CACHE_ARRAY -- requirements
Module: set_assoc_cache_array

Interface
REQ-001 SHALL have parameter SETS, default 16384, number of sets (power of two).
REQ-002 SHALL have parameter WAYS, default 8, associativity (power of two, 2..16).
REQ-003 SHALL have parameter TAG_W, default 12, tag width.
REQ-004 SHALL have parameter DATA_W, default 32, line data width.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port req_valid  input  1  request present.
REQ-008 SHALL have port req_ready  output  1  request accepted when valid and ready are high.
REQ-009 SHALL have port req_op  input  2  0=LOOKUP, 1=WRITE, 2=CLEAR, 3=PRINT.
REQ-010 SHALL have port req_set  input  log2(SETS)  target set.
REQ-011 SHALL have port req_tag  input  TAG_W  lookup tag.
REQ-012 SHALL have port req_way  input  log2(WAYS)  WRITE target way.
REQ-013 SHALL have port req_line  input  cache_line_t  WRITE payload: tag, MESI, data.
REQ-014 SHALL have port rsp_valid  output  1  one-cycle LOOKUP response strobe.
REQ-015 SHALL have port rsp_hit  output  1  tag match in a non-I way.
REQ-016 SHALL have port rsp_way  output  log2(WAYS)  hit way, else victim way.
REQ-017 SHALL have port rsp_line  output  cache_line_t  line in rsp_way.
REQ-018 SHALL have port busy  output  1  clear sweep in progress.

Function
REQ-019 SHALL implement FSM states IDLE, CLEAR, RESP; req_ready high only in IDLE.
REQ-020 LOOKUP accepted in cycle N SHALL produce rsp_valid with rsp_hit/rsp_way/rsp_line in cycle N+1 (RESP), returning to IDLE in N+2.
REQ-021 Hit SHALL require tag equal and MESI != I; multiple matches SHALL resolve to lowest way.
REQ-022 Miss victim SHALL be lowest-index I way, else way whose LRU counter == WAYS-1.
REQ-023 LRU: each way holds counter 0 (MRU)..WAYS-1 (LRU); counters in a set SHALL always be a permutation.
REQ-024 On LOOKUP hit or WRITE to way w with counter c: ways with counter < c increment, w becomes 0; LOOKUP miss SHALL leave LRU unchanged.
REQ-025 WRITE SHALL commit tag/MESI/data at the accepting edge, single cycle, no rsp_valid.
REQ-026 LOOKUP accepted the cycle after a WRITE to the same set SHALL observe the written line.
REQ-027 CLEAR SHALL sweep one set per cycle, SETS cycles, writing MESI=I, tag=0, data=0, LRU[w]=w; busy high throughout.
REQ-028 PRINT SHALL be accepted in one cycle and change no state.
REQ-029 Requests SHALL be ignored (not accepted) while req_ready low; requester holds them.

Reset
REQ-030 rst SHALL force FSM to CLEAR with sweep index 0; req_ready=0, rsp_valid=0, rsp_hit=0, rsp_way=0, rsp_line=0, busy=1.
REQ-031 rst asserted mid-sweep or mid-RESP SHALL restart sweep at index 0 and drop any pending response.
REQ-032 Array contents are valid only after the post-reset sweep ends (busy falls).

Configuration
REQ-033 With CACHE_DEBUG_PRINT_EN defined, PRINT SHALL $display time, set index and all WAYS lines of req_set; CLEAR completion SHALL $display "reset".
REQ-034 Without CACHE_DEBUG_PRINT_EN, PRINT SHALL be a silent one-cycle no-op and no $display SHALL exist.

Structure
REQ-035 cache_line_t, MESI enum (M,E,S,I) and req_op encoding SHALL live in my_struct_package.
REQ-036 LRU update/victim selection SHALL be sub-module lru_update, parameterised by WAYS, purely combinational.

Verification
REQ-037 Reset, wait SETS cycles -> busy falls; LOOKUP set 0 tag 0x000 -> rsp_hit=0, rsp_way=0.
REQ-038 WRITE set 5 way 3 tag 0xABC MESI=E data 0x12345678; LOOKUP set 5 tag 0xABC next cycle -> hit, way 3, data 0x12345678, LRU[3]=0.
REQ-039 Fill set 7 ways 0..7 in order, all MESI=S; LOOKUP miss -> rsp_way=0 (LRU==7).
REQ-040 WRITE way 2 MESI=I in full set 7; LOOKUP miss -> rsp_way=2.
REQ-041 Assert rst at sweep index 100 -> busy stays high, sweep restarts at 0, completes SETS cycles after release.
REQ-042 req_valid held during CLEAR -> no acceptance until busy falls; PRINT -> no array change.
